adapter_dl_20m: RTL and testbench

ADAPTER_DL_20M -- requirements
Module: adapter_dl_20m

---
 rtl/adapter_dl_20m.sv | 97 +++++++++
 tb/tb_adapter_dl_20m.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adapter_dl_20m.sv
// CPRI-to-DUC downlink adapter: one 8-lane I/Q word per strobe, serialized
// one sample per AXI-Stream beat through a hold register and a serializer.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   iq_rx_i/q, iq_rx_valid     - 8 x 16-bit I/Q lanes (lane 0 oldest), strobe
//   m_axis_tdata/tvalid/tready/tlast - DUC stream ({Q,I} per beat)
//   overflow, drop_cnt         - sticky drop flag, saturating drop count

module adapter_dl_20m (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] iq_rx_i,
  input  logic [127:0] iq_rx_q,
  input  logic         iq_rx_valid,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         overflow,
  output logic [7:0]   drop_cnt
);

  logic [127:0] hold_i;
  logic [127:0] hold_q;
  logic [127:0] ser_i;
  logic [127:0] ser_q;
  logic         hold_full;
  logic         busy;
  logic [2:0]   lane;

  logic         hs;
  logic         last_hs;
  logic         xfer;
  logic         take;
  logic         drop;
  logic [6:0]   base;

  assign hs      = busy & m_axis_tready;
  assign last_hs = hs & (lane == 3'd7);
  // hold moves to ser when ser is idle or finishing its last lane
  assign xfer    = hold_full & (~busy | last_hs);
  assign take    = iq_rx_valid & (~hold_full | xfer);
  assign drop    = iq_rx_valid & hold_full & ~xfer;
  assign base    = {lane, 4'b0000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      busy      <= 1'b0;
      lane      <= 3'd0;
      overflow  <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      if (take)
        hold_full <= 1'b1;
      else if (xfer)
        hold_full <= 1'b0;

      if (xfer) begin
        busy <= 1'b1;
        lane <= 3'd0;
      end else if (hs) begin
        lane <= lane + 3'd1;
        if (lane == 3'd7)
          busy <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hff)
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Payload registers need no reset: outputs are gated by busy
  always_ff @(posedge clk) begin
    if (take) begin
      hold_i <= iq_rx_i;
      hold_q <= iq_rx_q;
    end
    if (xfer) begin
      ser_i <= hold_i;
      ser_q <= hold_q;
    end
  end

  always_comb begin
    m_axis_tdata = 32'd0;
    if (busy)
      m_axis_tdata = {ser_q[base +: 16], ser_i[base +: 16]};
  end

  assign m_axis_tvalid = busy;
  assign m_axis_tlast  = busy & (lane == 3'd7);

endmodule

// File: tb/tb_adapter_dl_20m.sv
// Self-checking bench for adapter_dl_20m: directed steps, scoreboard queue
// of expected {tlast,tdata} beats, stall-stability monitor.

module tb_adapter_dl_20m;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] iq_rx_i;
  logic [127:0] iq_rx_q;
  logic         iq_rx_valid;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         overflow;
  logic [7:0]   drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [32:0] sb[$];
  logic        stall = 1'b0;
  logic [32:0] stall_data;

  adapter_dl_20m dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .iq_rx_i       (iq_rx_i),
    .iq_rx_q       (iq_rx_q),
    .iq_rx_valid   (iq_rx_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a word for the coming edge; caller ticks and deasserts valid
  task automatic load_word(input logic [127:0] wi, input logic [127:0] wq,
                           input bit accepted);
    iq_rx_i     = wi;
    iq_rx_q     = wq;
    iq_rx_valid = 1'b1;
    if (accepted)
      for (int k = 0; k < 8; k++)
        sb.push_back({k == 7, wq[16*k +: 16], wi[16*k +: 16]});
  endtask

  task automatic send(input logic [127:0] wi, input logic [127:0] wq,
                      input bit accepted);
    load_word(wi, wq, accepted);
    tick();
    iq_rx_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    tick();
    chk({tag, "_idle"}, 64'(m_axis_tvalid), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    sb.delete();
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard + AXIS stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      stall <= 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_data", 64'({m_axis_tlast, m_axis_tdata}),
            64'(stall_data));
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0)
          chk("beat", 64'({m_axis_tlast, m_axis_tdata}),
              64'(sb.pop_front()));
      end
      stall      <= (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
      stall_data <= {m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    logic [127:0] wi;
    logic [127:0] wq;
    logic [127:0] ai;
    logic [127:0] aq;
    int bubbles;
    bit pat [4];

    rst_n         = 1'b0;
    iq_rx_valid   = 1'b0;
    iq_rx_i       = '0;
    iq_rx_q       = '0;
    m_axis_tready = 1'b1;
    #2;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    tick();
    rst_n = 1'b1;

    // Single word with counting lanes, exact latency and tlast position
    for (int k = 0; k < 8; k++) begin
      wi[16*k +: 16] = 16'(k);
      wq[16*k +: 16] = 16'(16'h1000 + k);
    end
    send(wi, wq, 1'b1);
    chk("lat_edgeN_tvalid", 64'(m_axis_tvalid), 64'd0);
    tick();
    chk("lat_first_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("lat_first_tdata", 64'(m_axis_tdata), 64'h10000000);
    chk("lat_first_tlast", 64'(m_axis_tlast), 64'd0);
    for (int c = 1; c < 8; c++) begin
      tick();
      chk("single_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("single_tlast", 64'(m_axis_tlast), 64'(c == 7));
    end
    chk("single_last_tdata", 64'(m_axis_tdata), 64'h10070007);
    tick();
    chk("single_done", 64'(m_axis_tvalid), 64'd0);
    chk("single_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure 1,0,0,1
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    send(rnd128(), rnd128(), 1'b1);
    for (int c = 0; c < 40; c++) begin
      m_axis_tready = pat[c % 4];
      tick();
    end
    m_axis_tready = 1'b1;
    drain("bp_drain", 50);
    chk("bp_drop_cnt", 64'(drop_cnt), 64'd0);

    // Back-to-back words every 8 cycles, no bubbles
    bubbles = 0;
    for (int c = 0; c < 34; c++) begin
      iq_rx_valid = 1'b0;
      if (c % 8 == 0 && c < 32)
        load_word(rnd128(), rnd128(), 1'b1);
      tick();
      if (c >= 1 && c <= 32 && m_axis_tvalid !== 1'b1)
        bubbles++;
    end
    iq_rx_valid = 1'b0;
    chk("b2b_bubbles", 64'(bubbles), 64'd0);
    chk("b2b_overflow", 64'(overflow), 64'd0);
    drain("b2b_drain", 20);

    // Overflow: A in ser, B in hold, C dropped
    m_axis_tready = 1'b0;
    ai = rnd128();
    aq = rnd128();
    send(ai, aq, 1'b1);
    send(rnd128(), rnd128(), 1'b1);
    send(rnd128(), rnd128(), 1'b0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("ovf_hold_tdata", 64'(m_axis_tdata), 64'({aq[15:0], ai[15:0]}));
    tick();
    m_axis_tready = 1'b1;
    drain("ovf_drain", 40);
    chk("ovf_drop_cnt_kept", 64'(drop_cnt), 64'd1);

    // Saturation
    do_reset();
    m_axis_tready = 1'b0;
    for (int s = 0; s < 300; s++) begin
      load_word(rnd128(), rnd128(), s < 2);
      tick();
    end
    iq_rx_valid = 1'b0;
    chk("sat_drop_cnt", 64'(drop_cnt), 64'd255);
    chk("sat_overflow", 64'(overflow), 64'd1);
    tick();
    m_axis_tready = 1'b1;
    drain("sat_drain", 40);

    // Reset mid-word at lane 3
    send(rnd128(), rnd128(), 1'b1);
    for (int c = 0; c < 4; c++)
      tick();
    chk("mid_lane3_tvalid", 64'(m_axis_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("mid_rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    send(rnd128(), rnd128(), 1'b1);
    tick();
    chk("post_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    drain("post_rst_drain", 20);
    tick();
    chk("post_rst_quiet", 64'(m_axis_tvalid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
